// File: rtl/session_bus_ctrl.sv
// session_bus_ctrl: routes the granted master's beat stream onto one shared
// slave port, counts burst beats and closes the arbitration session with a
// one-cycle session_is_finished pulse. After the pulse it waits for the
// arbiter's lingering grant to drop before a new session can start.
//
// Optional feature: define SESSION_WATCHDOG_EN to abort a session after
// TIMEOUT+1 consecutive cycles without a handshake; session_err then pulses
// together with session_is_finished. Without the macro session_err stays 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   grant[3:0]            one-hot grant from the arbiter (held per session)
//   session_is_finished   registered one-cycle pulse closing the session
//   session_err           registered pulse on watchdog abort
//   m_valid/m_we/m_addr/m_wdata/m_len   per-master beat request fields
//   m_ready/m_rvalid      per-master accept and read-complete (combinational)
//   m_rdata               shared read data, pass-through of s_rdata
//   s_valid/s_we/s_addr/s_wdata, s_ready/s_rdata   shared slave port
module session_bus_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            grant,
    output logic                  session_is_finished,
    output logic                  session_err,
    input  logic [3:0]            m_valid,
    output logic [3:0]            m_ready,
    input  logic [3:0]            m_we,
    input  logic [4*ADDR_W-1:0]   m_addr,
    input  logic [4*DATA_W-1:0]   m_wdata,
    input  logic [4*LEN_W-1:0]    m_len,
    output logic [DATA_W-1:0]     m_rdata,
    output logic [3:0]            m_rvalid,
    output logic                  s_valid,
    output logic                  s_we,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    input  logic                  s_ready,
    input  logic [DATA_W-1:0]     s_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE, ST_DRAIN} state_t;

    state_t             state, state_nxt;
    logic [1:0]         idx, idx_nxt;
    logic [1:0]         grant_idx;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [LEN_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic               finish_nxt, err_nxt;
    logic               busy, hs, timeout_hit;

    // Lowest set grant bit wins; tolerates a non-one-hot grant.
    always_comb begin
        if (grant[0])      grant_idx = 2'd0;
        else if (grant[1]) grant_idx = 2'd1;
        else if (grant[2]) grant_idx = 2'd2;
        else               grant_idx = 2'd3;
    end

    // Combinational slave path: zero added latency per beat.
    assign busy    = (state == ST_BUSY);
    assign s_valid = busy & m_valid[idx];
    assign s_we    = busy & m_we[idx];
    assign s_addr  = m_addr[32'(idx)*ADDR_W +: ADDR_W];
    assign s_wdata = m_wdata[32'(idx)*DATA_W +: DATA_W];
    assign hs      = s_valid & s_ready;
    assign m_rdata = s_rdata;

    // Only the granted master sees ready / read completion.
    always_comb begin
        m_ready  = 4'b0000;
        m_rvalid = 4'b0000;
        if (busy) begin
            m_ready[idx]  = s_ready;
            m_rvalid[idx] = hs & ~m_we[idx];
        end
    end

`ifdef SESSION_WATCHDOG_EN
    localparam int unsigned STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;

    assign timeout_hit = busy & ~hs & (stall_cnt == STALL_W'(TIMEOUT));

    // Consecutive no-handshake cycles within the current session.
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (state == ST_IDLE) begin
            stall_cnt_nxt = '0;
        end else if (busy) begin
            stall_cnt_nxt = hs ? '0 : stall_cnt + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else     stall_cnt <= stall_cnt_nxt;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        len_nxt      = len;
        beat_cnt_nxt = beat_cnt;
        finish_nxt   = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant != 4'b0000) begin
                    idx_nxt      = grant_idx;
                    len_nxt      = m_len[32'(grant_idx)*LEN_W +: LEN_W];
                    beat_cnt_nxt = '0;
                    state_nxt    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (hs) begin
                    // Terminal compare before increment: counter never wraps.
                    if (beat_cnt == len) begin
                        state_nxt  = ST_DONE;
                        finish_nxt = 1'b1;
                    end else begin
                        beat_cnt_nxt = beat_cnt + LEN_W'(1);
                    end
                end else if (timeout_hit) begin
                    state_nxt  = ST_DONE;
                    finish_nxt = 1'b1;
                    err_nxt    = 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_DRAIN;
            // Wait out the arbiter's registered grant linger.
            ST_DRAIN: if (grant == 4'b0000) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            idx                 <= 2'd0;
            len                 <= '0;
            beat_cnt            <= '0;
            session_is_finished <= 1'b0;
            session_err         <= 1'b0;
        end else begin
            state               <= state_nxt;
            idx                 <= idx_nxt;
            len                 <= len_nxt;
            beat_cnt            <= beat_cnt_nxt;
            session_is_finished <= finish_nxt;
            session_err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_session_bus_ctrl.sv
// Self-checking bench for session_bus_ctrl: directed and randomized sessions
// checked against a transaction-level model (expected master, beat count,
// per-beat routing), plus grant linger, reset mid-burst and watchdog cases.
module tb_session_bus_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      grant;
    logic            session_is_finished;
    logic            session_err;
    logic [3:0]      m_valid;
    logic [3:0]      m_ready;
    logic [3:0]      m_we;
    logic [4*AW-1:0] m_addr;
    logic [4*DW-1:0] m_wdata;
    logic [4*LW-1:0] m_len;
    logic [DW-1:0]   m_rdata;
    logic [3:0]      m_rvalid;
    logic            s_valid;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_ready;
    logic [DW-1:0]   s_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    session_bus_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst(rst), .grant(grant),
        .session_is_finished(session_is_finished), .session_err(session_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_len(m_len),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic rand_fields();
        m_we    = 4'($urandom);
        m_addr  = {$urandom, $urandom, $urandom, $urandom};
        m_wdata = {$urandom, $urandom, $urandom, $urandom};
        s_rdata = $urandom;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_svalid"}, 64'(s_valid), 64'd0);
        chk({tag, "_mready"}, 64'(m_ready), 64'd0);
        chk({tag, "_rvalid"}, 64'(m_rvalid), 64'd0);
    endtask

    // One complete session: grant in IDLE, L+1 beats, finish, linger, release.
    // we_mode: 0 = reads, 1 = writes, 2 = random. Entered/left with DUT idle.
    task automatic session(input logic [3:0] g, input int L, input int rdy_pct,
                           input int vld_pct, input int we_mode, input int linger);
        int m, beats, cyc, stall;
        logic hs;
        logic [3:0] exp_rdy, exp_rv;
        m = lowest(g);
        rand_fields();
        grant   = g;
        m_len   = 16'($urandom);
        m_len[m*LW +: LW] = LW'(L);
        m_valid = 4'hf;
        s_ready = 1'b1;
        #1;
        chk_quiet("start");
        chk("start_fin", 64'(session_is_finished), 64'd0);
        tick();
        beats = 0; cyc = 0; stall = 0;
        while (beats < L + 1 && cyc < 400) begin
            rand_fields();
            m_len   = 16'($urandom);   // must be ignored after session start
            m_valid = 4'($urandom);
            m_valid[m] = ($urandom_range(99) < 32'(vld_pct));
            s_ready = ($urandom_range(99) < 32'(rdy_pct));
            if (stall >= 8) begin
                m_valid[m] = 1'b1;
                s_ready    = 1'b1;
            end
            if (we_mode < 2) m_we[m] = (we_mode == 1);
            #1;
            hs = m_valid[m] & s_ready;
            exp_rdy = 4'b0; exp_rdy[m] = s_ready;
            exp_rv  = 4'b0; exp_rv[m]  = hs & ~m_we[m];
            chk("busy_svalid", 64'(s_valid), 64'(m_valid[m]));
            chk("busy_mready", 64'(m_ready), 64'(exp_rdy));
            chk("busy_rvalid", 64'(m_rvalid), 64'(exp_rv));
            chk("busy_swe",    64'(s_we), 64'(m_we[m]));
            chk("busy_fin",    64'(session_is_finished), 64'd0);
            chk("busy_err",    64'(session_err), 64'd0);
            chk("rdata_pass",  64'(m_rdata), 64'(s_rdata));
            if (hs) begin
                chk("beat_addr",  64'(s_addr),  64'(m_addr[m*AW +: AW]));
                chk("beat_wdata", 64'(s_wdata), 64'(m_wdata[m*DW +: DW]));
                beats++;
                stall = 0;
            end else begin
                stall++;
            end
            cyc++;
            tick();
        end
        chk("busy_budget", 64'(cyc < 400), 64'd1);
        m_valid = 4'hf;
        s_ready = 1'b1;
        #1;
        chk("done_fin", 64'(session_is_finished), 64'd1);
        chk("done_err", 64'(session_err), 64'd0);
        chk_quiet("done");
        tick();
        for (int k = 0; k < linger; k++) begin
            #1;
            chk("linger_fin", 64'(session_is_finished), 64'd0);
            chk_quiet("linger");
            tick();
        end
        grant = 4'b0000;
        #1;
        chk("drain_fin", 64'(session_is_finished), 64'd0);
        chk_quiet("drain");
        tick();
    endtask

    initial begin
        int nfin;
        logic [3:0] g;
        rst = 1'b1; grant = 4'b0001; m_valid = 4'hf; s_ready = 1'b1;
        m_len = '0;
        rand_fields();
        tick();
        tick();
        #1;
        chk("rst_fin", 64'(session_is_finished), 64'd0);
        chk("rst_err", 64'(session_err), 64'd0);
        chk_quiet("rst");
        rst = 1'b0; grant = 4'b0000;
        tick();

        // Single beat write, burst read with stalls, linger then master 3.
        session(4'b0001, 0, 100, 100, 1, 0);
        session(4'b0100, 3, 50, 100, 0, 1);
        session(4'b0001, 2, 100, 100, 2, 1);
        session(4'b1000, 1, 70, 80, 2, 2);
        // Maximum burst length, continuous and with stalls.
        session(4'b0010, 15, 100, 100, 2, 1);
        session(4'b0100, 15, 60, 70, 0, 0);
        // Non-one-hot grant resolves to the lowest index.
        session(4'b1010, 4, 80, 80, 2, 1);

        for (int n = 0; n < 30; n++) begin
            g = 4'($urandom_range(15, 1));
            session(g, int'($urandom_range(15)), int'($urandom_range(100, 30)),
                    int'($urandom_range(100, 30)), 2, int'($urandom_range(2)));
        end

        // Reset after beat 2 of an 8-beat burst.
        grant = 4'b0010; m_len = '0; m_len[1*LW +: LW] = LW'(7);
        m_valid = 4'hf; s_ready = 1'b1;
        tick();
        #1; chk("rb_beat1", 64'(s_valid), 64'd1);
        tick();
        #1; chk("rb_beat2", 64'(s_valid), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; grant = 4'b0000;
        nfin = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_quiet("rb_after");
            if (session_is_finished) nfin++;
            tick();
        end
        chk("rb_no_finish", 64'(nfin), 64'd0);
        session(4'b0001, 1, 100, 100, 2, 0);

        // Stalled session: watchdog abort or indefinite hold.
        grant = 4'b1000; m_len = '0; m_len[3*LW +: LW] = LW'(5);
        m_valid = 4'hf; s_ready = 1'b0;
        tick();
`ifdef SESSION_WATCHDOG_EN
        for (int i = 1; i <= 11; i++) begin
            #1;
            chk("wd_wait_fin", 64'(session_is_finished), 64'd0);
            chk("wd_wait_err", 64'(session_err), 64'd0);
            chk("wd_wait_sv",  64'(s_valid), 64'd1);
            tick();
        end
        #1;
        chk("wd_fin", 64'(session_is_finished), 64'd1);
        chk("wd_err", 64'(session_err), 64'd1);
        tick();
        grant = 4'b0000;
        #1;
        chk("wd_drain_fin", 64'(session_is_finished), 64'd0);
        chk("wd_drain_err", 64'(session_err), 64'd0);
        tick();
`else
        nfin = 0;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (session_is_finished || session_err) nfin++;
            tick();
        end
        chk("nowd_no_finish", 64'(nfin), 64'd0);
        chk("nowd_hold", 64'(s_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; grant = 4'b0000;
        tick();
`endif
        session(4'b0100, 2, 90, 90, 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
